cb_dina_map: RTL and testbench
==============================

// Module: cb_dina_map
// PURPOSE
//  Write-side lane mapper for the covariance bank (CB) port A. It routes operands into the L-lane CB_dina word with per-lane write enables:
//   - systolic-array results (C path)
//   - temp-bank readback (TB path, transpose/new-landmark diagonal)
//   - nonlinear-unit results (NL path: xk, yk, xita, lkx, lky)
//  It is the inverse of the CB douta mapper and applies the same sel encoding, direction codes and l_k_0 landmark-slot rule.
// PARAMETERS
//  X               4   PE rows / C_dout lanes (must equal L)
//  L               4   CB lanes per word
//  RSA_DW          32  lane data width, signed
//  SEQ_CNT_DW      10  sequence-counter width
//  CB_DINA_SEL_DW  5   select width: [4:2] source, [1:0] direction
// PORTS
//  clk            in   1            clock
//  sys_rst        in   1            synchronous active-high reset
//  CB_dina_sel    in   5            source/direction select
//  l_k_0          in   1            landmark slot: 1=lanes0/1, 0=lanes2/3
//  seq_cnt_in     in   SEQ_CNT_DW   sequence counter from the controller
//  C_CB_dina      in   X*RSA_DW     systolic-array result row
//  TB_CB_dina     in   X*RSA_DW     temp-bank port B read data
//  nl_wr_start    in   1            pulse: latch NL results and start writeback
//  xk_new,yk_new,xita_new,lkx_new,lky_new  in  RSA_DW each  NL results
//  CB_dina        out  L*RSA_DW     registered CB write data
//  CB_wea         out  L            registered per-lane write enables
//  nl_wr_slot     out  1            0=pose row, 1=landmark row (address mux select)
//  nl_busy        out  1            NL writeback in progress
//  nl_done        out  1            one-cycle pulse after the last NL write
// BEHAVIOUR
//  - Reset: CB_dina=0, CB_wea=0, nl_wr_slot=0, nl_busy=0, nl_done=0; NL FSM goes to IDLE. Reset mid-writeback aborts the writeback with no done pulse.
//  - sel[4:2] source codes: 000 IDLE, 001 C, 100 TB, 111 NL; any other code behaves as IDLE.
//  - sel[1:0] direction codes: 00 IDLE, 01 POS, 10 NEG, 11 NEW.
//  - C and TB paths have 1-cycle latency from input to CB_dina/CB_wea.
//  - Source IDLE or direction IDLE: CB_dina=0, CB_wea=0.
//  - C path:
//     POS: lane i <= C lane i; wea=1111.
//     NEG: lane i <= C lane L-1-i; wea=1111.
//     NEW, l_k_0=1: lane0 <= C0, lane1 <= C1; wea=0011.
//     NEW, l_k_0=0: lane2 <= C0, lane3 <= C1; wea=1100.
//     Lanes with wea=0 are driven to 0.
//  - TB path:
//     POS/NEG: same mapping as the C path.
//     NEW: uses seq_cnt_in delayed 2 cycles (sd) by an internal shift register that runs every cycle.
//     lo = (l_k_0 ? lane0 : lane2), hi = (l_k_0 ? lane1 : lane3):
//       sd=0: hi <= TB3
//       sd=1: lo <= TB0
//       sd=2: hi <= TB0, lo <= TB1
//       sd=3: hi <= TB1, lo <= TB2
//       sd=4: hi <= TB2, lo <= TB3
//       other sd: wea=0
//     wea is set only on the lanes written.
//  - NL FSM states: IDLE -> POSE -> LMK -> DONE -> IDLE.
//     IDLE: nl_wr_start with source=NL latches all five inputs and moves to POSE. nl_wr_start is ignored in any other state or with any other source.
//     POSE (1 cycle): lane0=xk, lane1=yk, lane2=xita, lane3=0; wea=0111; nl_wr_slot=0.
//     LMK (1 cycle): l_k_0=1 -> lane0=lkx, lane1=lky, wea=0011; l_k_0=0 -> lane2=lkx, lane3=lky, wea=1100; nl_wr_slot=1.
//     DONE: nl_done=1 for one cycle; CB_dina=0, wea=0.
//     nl_busy is high in POSE, LMK and DONE.
//     While nl_busy=1 the FSM owns CB_dina/CB_wea and the C/TB paths are suppressed.
//  - l_k_0 is sampled in the cycle that produces each output word and is not latched.
//  - Arithmetic: none. Lanes pass through bit-exact with no sign extension or truncation.
// TESTING
//  1. sel=001_01, C lanes={4,3,2,1} (lane3..0) -> next cycle CB_dina lanes={4,3,2,1}, wea=1111.
//  2. sel=001_10, same C -> CB_dina lanes3..0={1,2,3,4}, wea=1111. Then sel=001_11, l_k_0=0 -> lanes3..0={2,1,0,0}, wea=1100.
//  3. sel=100_11, l_k_0=1, TB lanes={D,C,B,A}, seq_cnt 0..5 -> outputs 3 cycles after each count:
//     sd0: lane1=D, wea=0010
//     sd1: lane0=A, wea=0001
//     sd2: lane1=A, lane0=B, wea=0011
//     sd3: lane1=B, lane0=C
//     sd4: lane1=C, lane0=D
//     sd5: wea=0
//  4. sel=111_xx, nl_wr_start with xk=10, yk=20, xita=30, lkx=40, lky=50, l_k_0=0 ->
//     POSE {0,30,20,10} wea=0111 slot0; LMK {50,40,0,0} wea=1100 slot1; nl_done pulse; busy high 3 cycles.
//  5. Second nl_wr_start during LMK -> ignored, exactly one done pulse. C path sel applied while busy -> no C write.
//  6. sys_rst asserted during LMK -> next cycle all outputs 0, FSM IDLE, no nl_done. A fresh start then works normally.

Source files
------------

// File: rtl/cb_dina_map.sv
// ============================================================================
// cb_dina_map : covariance-bank port-A write-lane mapper (C / TB / NL paths)
// Rev 1.0
// ============================================================================
`default_nettype none

module cb_dina_map #(
  parameter int X              = 4,
  parameter int L              = 4,
  parameter int RSA_DW         = 32,
  parameter int SEQ_CNT_DW     = 10,
  parameter int CB_DINA_SEL_DW = 5
) (
  input  logic                      clk,
  input  logic                      sys_rst,
  input  logic [CB_DINA_SEL_DW-1:0] CB_dina_sel,
  input  logic                      l_k_0,
  input  logic [SEQ_CNT_DW-1:0]     seq_cnt_in,
  input  logic [X*RSA_DW-1:0]       C_CB_dina,
  input  logic [X*RSA_DW-1:0]       TB_CB_dina,
  input  logic                      nl_wr_start,
  input  logic [RSA_DW-1:0]         xk_new,
  input  logic [RSA_DW-1:0]         yk_new,
  input  logic [RSA_DW-1:0]         xita_new,
  input  logic [RSA_DW-1:0]         lkx_new,
  input  logic [RSA_DW-1:0]         lky_new,
  output logic [L*RSA_DW-1:0]       CB_dina,
  output logic [L-1:0]              CB_wea,
  output logic                      nl_wr_slot,
  output logic                      nl_busy,
  output logic                      nl_done
);

  localparam logic [2:0] SRC_C  = 3'b001;
  localparam logic [2:0] SRC_TB = 3'b100;
  localparam logic [2:0] SRC_NL = 3'b111;
  localparam logic [1:0] DIR_POS = 2'b01;
  localparam logic [1:0] DIR_NEG = 2'b10;
  localparam logic [1:0] DIR_NEW = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POSE = 2'd1,
    S_LMK  = 2'd2,
    S_DONE = 2'd3
  } nl_state_t;

  nl_state_t state;

  logic [2:0]              src;
  logic [1:0]              dir;
  logic [SEQ_CNT_DW-1:0]   seq_d1, seq_d2;
  logic [RSA_DW-1:0]       lkx_q, lky_q;
  logic [X*RSA_DW-1:0]     src_word;
  logic [2*RSA_DW-1:0]     pair_dina;
  logic [1:0]              pair_wea;
  logic [L*RSA_DW-1:0]     path_dina;
  logic [L-1:0]            path_wea;

  assign src      = CB_dina_sel[4:2];
  assign dir      = CB_dina_sel[1:0];
  assign src_word = (src == SRC_C) ? C_CB_dina : TB_CB_dina;

  // NEW direction writes a {hi, lo} lane pair placed at lanes 1:0 or 3:2 by l_k_0
  always_comb begin
    pair_dina = '0;
    pair_wea  = 2'b00;
    if (src == SRC_C) begin
      pair_dina = src_word[2*RSA_DW-1:0];
      pair_wea  = 2'b11;
    end else begin
      case (seq_d2)
        SEQ_CNT_DW'(0): begin
          pair_dina[RSA_DW +: RSA_DW] = src_word[3*RSA_DW +: RSA_DW];
          pair_wea                    = 2'b10;
        end
        SEQ_CNT_DW'(1): begin
          pair_dina[0 +: RSA_DW] = src_word[0 +: RSA_DW];
          pair_wea               = 2'b01;
        end
        SEQ_CNT_DW'(2): begin
          pair_dina = {src_word[0 +: RSA_DW], src_word[RSA_DW +: RSA_DW]};
          pair_wea  = 2'b11;
        end
        SEQ_CNT_DW'(3): begin
          pair_dina = {src_word[RSA_DW +: RSA_DW], src_word[2*RSA_DW +: RSA_DW]};
          pair_wea  = 2'b11;
        end
        SEQ_CNT_DW'(4): begin
          pair_dina = {src_word[2*RSA_DW +: RSA_DW], src_word[3*RSA_DW +: RSA_DW]};
          pair_wea  = 2'b11;
        end
        default: begin
          pair_dina = '0;
          pair_wea  = 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    path_dina = '0;
    path_wea  = '0;
    if (src == SRC_C || src == SRC_TB) begin
      case (dir)
        DIR_POS: begin
          path_dina = src_word;
          path_wea  = '1;
        end
        DIR_NEG: begin
          for (int i = 0; i < L; i++) begin
            path_dina[i*RSA_DW +: RSA_DW] = src_word[(L-1-i)*RSA_DW +: RSA_DW];
          end
          path_wea = '1;
        end
        DIR_NEW: begin
          if (l_k_0) begin
            path_dina[2*RSA_DW-1:0] = pair_dina;
            path_wea[1:0]           = pair_wea;
          end else begin
            path_dina[4*RSA_DW-1:2*RSA_DW] = pair_dina;
            path_wea[3:2]                  = pair_wea;
          end
        end
        default: begin
          path_dina = '0;
          path_wea  = '0;
        end
      endcase
    end
  end

  // Data paths are only honoured in IDLE; the NL writeback owns the port otherwise
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      seq_d1     <= '0;
      seq_d2     <= '0;
      lkx_q      <= '0;
      lky_q      <= '0;
      CB_dina    <= '0;
      CB_wea     <= '0;
      nl_wr_slot <= 1'b0;
      nl_busy    <= 1'b0;
      nl_done    <= 1'b0;
    end else begin
      seq_d1     <= seq_cnt_in;
      seq_d2     <= seq_d1;
      nl_wr_slot <= 1'b0;
      nl_done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (nl_wr_start && src == SRC_NL) begin
            state   <= S_POSE;
            nl_busy <= 1'b1;
            lkx_q   <= lkx_new;
            lky_q   <= lky_new;
            CB_dina <= {{RSA_DW{1'b0}}, xita_new, yk_new, xk_new};
            CB_wea  <= 4'b0111;
          end else begin
            CB_dina <= path_dina;
            CB_wea  <= path_wea;
          end
        end
        S_POSE: begin
          state      <= S_LMK;
          nl_wr_slot <= 1'b1;
          if (l_k_0) begin
            CB_dina <= {{(2*RSA_DW){1'b0}}, lky_q, lkx_q};
            CB_wea  <= 4'b0011;
          end else begin
            CB_dina <= {lky_q, lkx_q, {(2*RSA_DW){1'b0}}};
            CB_wea  <= 4'b1100;
          end
        end
        S_LMK: begin
          state   <= S_DONE;
          nl_done <= 1'b1;
          CB_dina <= '0;
          CB_wea  <= '0;
        end
        default: begin
          state   <= S_IDLE;
          nl_busy <= 1'b0;
          CB_dina <= '0;
          CB_wea  <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cb_dina_map.sv
// ============================================================================
// tb_cb_dina_map : randomized + directed self-checking bench for cb_dina_map
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cb_dina_map;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic [4:0]    CB_dina_sel;
  logic          l_k_0;
  logic [9:0]    seq_cnt_in;
  logic [127:0]  C_CB_dina, TB_CB_dina;
  logic          nl_wr_start;
  logic [31:0]   xk_new, yk_new, xita_new, lkx_new, lky_new;
  logic [127:0]  CB_dina;
  logic [3:0]    CB_wea;
  logic          nl_wr_slot, nl_busy, nl_done;

  always #5 clk = ~clk;

  cb_dina_map dut (
    .clk(clk), .sys_rst(sys_rst), .CB_dina_sel(CB_dina_sel), .l_k_0(l_k_0),
    .seq_cnt_in(seq_cnt_in), .C_CB_dina(C_CB_dina), .TB_CB_dina(TB_CB_dina),
    .nl_wr_start(nl_wr_start), .xk_new(xk_new), .yk_new(yk_new), .xita_new(xita_new),
    .lkx_new(lkx_new), .lky_new(lky_new), .CB_dina(CB_dina), .CB_wea(CB_wea),
    .nl_wr_slot(nl_wr_slot), .nl_busy(nl_busy), .nl_done(nl_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state: writeback phase (0 none, 1 pose, 2 landmark, 3 done)
  int          phase = 0;
  logic [31:0] m_lkx = '0, m_lky = '0;
  logic [9:0]  hist1 = '0, hist2 = '0;
  int          done_seen = 0;

  task automatic step(input string tag);
    logic [31:0] s [4];
    logic [31:0] e [4];
    logic [3:0]  ew;
    logic        eslot, edone;
    int          np, sd, lo, hi;
    logic [2:0]  src;
    logic [1:0]  dir;
    src = CB_dina_sel[4:2];
    dir = CB_dina_sel[1:0];
    sd  = int'(hist2);
    for (int i = 0; i < 4; i++) begin
      s[i] = (src == 3'b001) ? C_CB_dina[i*32 +: 32] : TB_CB_dina[i*32 +: 32];
      e[i] = '0;
    end
    ew = '0; eslot = 1'b0; edone = 1'b0; np = 0;
    lo = l_k_0 ? 0 : 2;
    hi = lo + 1;
    if (!sys_rst) begin
      if (phase == 0 && nl_wr_start && src == 3'b111) begin
        np = 1;
        e[0] = xk_new; e[1] = yk_new; e[2] = xita_new; ew = 4'b0111;
        m_lkx = lkx_new; m_lky = lky_new;
      end else if (phase == 1) begin
        np = 2; eslot = 1'b1;
        e[lo] = m_lkx; e[hi] = m_lky; ew[lo] = 1'b1; ew[hi] = 1'b1;
      end else if (phase == 2) begin
        np = 3; edone = 1'b1;
      end else if (phase == 0 && (src == 3'b001 || src == 3'b100)) begin
        if (dir == 2'b01) begin
          for (int i = 0; i < 4; i++) e[i] = s[i];
          ew = 4'b1111;
        end else if (dir == 2'b10) begin
          for (int i = 0; i < 4; i++) e[i] = s[3-i];
          ew = 4'b1111;
        end else if (dir == 2'b11 && src == 3'b001) begin
          e[lo] = s[0]; e[hi] = s[1]; ew[lo] = 1'b1; ew[hi] = 1'b1;
        end else if (dir == 2'b11) begin
          if (sd >= 1 && sd <= 4) begin e[lo] = s[sd-1]; ew[lo] = 1'b1; end
          if (sd >= 2 && sd <= 4) begin e[hi] = s[sd-2]; ew[hi] = 1'b1; end
          if (sd == 0)            begin e[hi] = s[3];    ew[hi] = 1'b1; end
        end
      end
      hist2 = hist1;
      hist1 = seq_cnt_in;
    end else begin
      hist1 = '0;
      hist2 = '0;
    end
    @(posedge clk);
    #1;
    check({tag, "_dina"}, CB_dina, {e[3], e[2], e[1], e[0]});
    check({tag, "_wea"},  128'(CB_wea), 128'(ew));
    check({tag, "_slot"}, 128'(nl_wr_slot), 128'(eslot));
    check({tag, "_busy"}, 128'(nl_busy), 128'(np != 0));
    check({tag, "_done"}, 128'(nl_done), 128'(edone));
    if (nl_done) done_seen++;
    phase = np;
  endtask

  initial begin
    sys_rst = 1'b1; CB_dina_sel = '0; l_k_0 = 1'b0; seq_cnt_in = '0;
    C_CB_dina = '0; TB_CB_dina = '0; nl_wr_start = 1'b0;
    xk_new = '0; yk_new = '0; xita_new = '0; lkx_new = '0; lky_new = '0;
    step("rst");
    check("rst_dina_zero", CB_dina, 128'd0);
    sys_rst = 1'b0;
    step("idle0"); step("idle1");

    // C path POS / NEG / NEW
    CB_dina_sel = 5'b001_01;
    C_CB_dina = {32'd4, 32'd3, 32'd2, 32'd1};
    step("c_pos");
    check("t1_dina", CB_dina, {32'd4, 32'd3, 32'd2, 32'd1});
    CB_dina_sel = 5'b001_10;
    step("c_neg");
    check("t2_neg", CB_dina, {32'd1, 32'd2, 32'd3, 32'd4});
    CB_dina_sel = 5'b001_11; l_k_0 = 1'b0;
    step("c_new");
    check("t2_new", {CB_dina, 124'(0), CB_wea} , {{32'd2, 32'd1, 32'd0, 32'd0}, 124'(0), 4'b1100});

    // TB path NEW with the delayed sequence counter
    CB_dina_sel = 5'b100_11; l_k_0 = 1'b1;
    TB_CB_dina = {32'hD, 32'hC, 32'hB, 32'hA};
    for (int k = 0; k < 8; k++) begin
      seq_cnt_in = 10'(k < 6 ? k : 5);
      step("tb_new");
      if (k == 4) check("t3_sd2", {CB_dina[63:0], 60'(0), CB_wea}, {32'hA, 32'hB, 60'(0), 4'b0011});
    end
    CB_dina_sel = '0;
    step("idle2");

    // NL writeback
    CB_dina_sel = 5'b111_00; l_k_0 = 1'b0;
    xk_new = 32'd10; yk_new = 32'd20; xita_new = 32'd30; lkx_new = 32'd40; lky_new = 32'd50;
    nl_wr_start = 1'b1;
    step("nl_pose");
    nl_wr_start = 1'b0;
    check("t4_pose", CB_dina, {32'd0, 32'd30, 32'd20, 32'd10});
    step("nl_lmk");
    check("t4_lmk", {CB_dina, 123'(0), CB_wea, nl_wr_slot}, {{32'd50, 32'd40, 64'd0}, 123'(0), 4'b1100, 1'b1});
    step("nl_done");
    check("t4_donepulse", 128'(nl_done), 128'd1);
    step("nl_idle");

    // Second start during LMK ignored; C path suppressed while busy
    done_seen = 0;
    nl_wr_start = 1'b1;
    step("t5_pose");
    nl_wr_start = 1'b0; CB_dina_sel = 5'b001_01;
    step("t5_lmk");
    CB_dina_sel = 5'b111_00; nl_wr_start = 1'b1;
    step("t5_done");
    nl_wr_start = 1'b0; CB_dina_sel = 5'b001_01;
    step("t5_x0"); CB_dina_sel = '0;
    step("t5_x1"); step("t5_x2");
    check("t5_one_done", 128'(done_seen), 128'd1);

    // Reset during LMK aborts without a done pulse
    done_seen = 0;
    CB_dina_sel = 5'b111_00; nl_wr_start = 1'b1;
    step("t6_pose");
    nl_wr_start = 1'b0;
    step("t6_lmk");
    sys_rst = 1'b1;
    step("t6_rst");
    sys_rst = 1'b0;
    step("t6_a"); step("t6_b");
    check("t6_no_done", 128'(done_seen), 128'd0);
    nl_wr_start = 1'b1;
    step("t6_restart");
    nl_wr_start = 1'b0;
    step("t6_c"); step("t6_d"); step("t6_e");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      CB_dina_sel = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) CB_dina_sel[4:2] = 3'b100;
      l_k_0       = 1'($urandom_range(0, 1));
      seq_cnt_in  = 10'($urandom_range(0, 6));
      C_CB_dina   = {$urandom, $urandom, $urandom, $urandom};
      TB_CB_dina  = {$urandom, $urandom, $urandom, $urandom};
      nl_wr_start = ($urandom_range(0, 5) == 0);
      xk_new = $urandom; yk_new = $urandom; xita_new = $urandom;
      lkx_new = $urandom; lky_new = $urandom;
      sys_rst = ($urandom_range(0, 79) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
